// File: rtl/control_sequencer_if.sv
// Control bundle between the instruction sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath.
interface control_sequencer_if;
   logic        stop;
   logic [31:0] IR;
   logic        PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
   logic [15:0] Rin;
   logic [15:0] Rout;
   logic [4:0]  alu_op;
   logic        run;

   modport master (
      input  stop, IR,
      output PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
      output Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
      output Rin, Rout, alu_op, run
   );

   modport slave (
      output stop, IR,
      input  PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
      input  Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
      input  Rin, Rout, alu_op, run
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore sequencer for a three-register ALU instruction: fetch in T0..T2, then
// operand B, operand C/ALU, and writeback in T3..T5. HALT holds until clear.
module control_sequencer (
   input  logic                 clock,
   input  logic                 clear,
   control_sequencer_if.master  bus
);
   localparam logic [4:0] OpAdd = 5'b00000;
   localparam logic [4:0] OpSub = 5'b00001;
   localparam logic [4:0] OpAnd = 5'b01010;
   localparam logic [4:0] OpOr  = 5'b01011;

   typedef enum logic [2:0] {StRst, StT0, StT1, StT2, StT3, StT4, StT5, StHalt} state_e;

   state_e state_q, state_d;

   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic       op_ok;
   logic       unused_ir;

   assign opcode    = bus.IR[31:27];
   assign ra        = bus.IR[26:23];
   assign rb        = bus.IR[22:19];
   assign rc        = bus.IR[18:15];
   assign unused_ir = ^bus.IR[14:0];
   assign op_ok     = (opcode == OpAdd) || (opcode == OpSub) ||
                      (opcode == OpAnd) || (opcode == OpOr);

   // clear wins over every transition, including stop in T0
   always_ff @(posedge clock) begin
      if (clear) state_q <= StRst;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      bus.PCout    = 1'b0;
      bus.IncPC    = 1'b0;
      bus.MARin    = 1'b0;
      bus.memRead  = 1'b0;
      bus.MDRin    = 1'b0;
      bus.MDRout   = 1'b0;
      bus.IRin     = 1'b0;
      bus.Yin      = 1'b0;
      bus.Zin      = 1'b0;
      bus.Zlowout  = 1'b0;
      bus.Zhighout = 1'b0;
      bus.HIin     = 1'b0;
      bus.LOin     = 1'b0;
      bus.HIout    = 1'b0;
      bus.LOout    = 1'b0;
      bus.Rin      = 16'h0000;
      bus.Rout     = 16'h0000;
      bus.alu_op   = 5'b00000;
      bus.run      = 1'b1;

      unique case (state_q)
         StRst: state_d = StT0;
         StT0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            state_d   = bus.stop ? StHalt : StT1;
         end
         StT1: begin
            bus.memRead = 1'b1;
            bus.MDRin   = 1'b1;
            state_d     = StT2;
         end
         StT2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = StT3;
         end
         StT3: begin
            if (op_ok) begin
               bus.Yin      = 1'b1;
               bus.Rout[rb] = 1'b1;
               state_d      = StT4;
            end else begin
               state_d = StHalt;
            end
         end
         StT4: begin
            bus.Zin      = 1'b1;
            bus.Rout[rc] = 1'b1;
            bus.alu_op   = opcode;
            state_d      = StT5;
         end
         StT5: begin
            bus.Zlowout = 1'b1;
            bus.Rin[ra] = 1'b1;
            state_d     = StT0;
         end
         StHalt: begin
            bus.run = 1'b0;
            state_d = StHalt;
         end
         default: state_d = StRst;
      endcase
   end
endmodule
